// File: rtl/handshake_pkg.sv
// handshake_pkg: shared payload width and beat type for the handshake slices
package handshake_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef logic [DEFAULT_DATA_W-1:0] beat_t;

endpackage

// File: rtl/handshake_type1_skid.sv
// handshake_type1_skid: one spare beat register plus the registered upstream ready it drives
module handshake_type1_skid
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] beat,
    output logic              full,
    output logic [DATA_W-1:0] entry,
    output logic              ready
);

    logic full_next;

    // a beat parks here only while the output is stalled, so load and drain never coincide
    always_comb begin
        full_next = load ? 1'b1 : (drain ? 1'b0 : full);
    end

    // ready is registered from the next occupancy, keeping ready_post_i off the upstream path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full  <= 1'b0;
            entry <= '0;
            ready <= 1'b0;
        end else begin
            full  <= full_next;
            ready <= ~full_next;
            if (load)
                entry <= beat;
        end
    end

endmodule

// File: rtl/handshake_type1.sv
// handshake_type1: registered valid/ready slice; define HANDSHAKE_TYPE1_SKID_EN for the skid variant
module handshake_type1
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_pre_i,
    input  logic [DATA_W-1:0] data_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    output logic [DATA_W-1:0] data_post_o,
    input  logic              ready_post_i
);

    logic              out_en;
    logic              next_valid;
    logic              capture;
    logic [DATA_W-1:0] next_data;

`ifdef HANDSHAKE_TYPE1_SKID_EN
    logic              skid_full;
    logic [DATA_W-1:0] skid_entry;
    logic              skid_load;
    logic              take;

    assign take      = valid_pre_i & ready_pre_o;
    assign skid_load = take & valid_post_o & ~ready_post_i;

    handshake_type1_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .drain (ready_post_i),
        .beat  (data_pre_i),
        .full  (skid_full),
        .entry (skid_entry),
        .ready (ready_pre_o)
    );

    // a parked beat has priority over upstream, which is blocked while the entry is full
    always_comb begin
        out_en     = skid_full ? ready_post_i : (~valid_post_o | ready_post_i);
        next_valid = skid_full | take;
        capture    = skid_full | take;
        next_data  = skid_full ? skid_entry : data_pre_i;
    end
`else
    assign ready_pre_o = rst_n & (~valid_post_o | ready_post_i);

    // the output reloads whenever it is empty or being drained this cycle
    always_comb begin
        out_en     = ready_pre_o;
        next_valid = valid_pre_i;
        capture    = valid_pre_i;
        next_data  = data_pre_i;
    end
`endif

    // output register; data moves only on a captured beat so it is quiet on idle cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_post_o <= 1'b0;
            data_post_o  <= '0;
        end else if (out_en) begin
            valid_post_o <= next_valid;
            if (capture)
                data_post_o <= next_data;
        end
    end

endmodule

// File: tb/tb_handshake_type1.sv
// tb_handshake_type1: directed checks of reset, streaming, backpressure, drain/fill and random stalls
module tb_handshake_type1;
    import handshake_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_pre_i;
    beat_t      data_pre_i;
    logic       ready_pre_o;
    logic       valid_post_o;
    beat_t      data_post_o;
    logic       ready_post_i;

    int checks = 0;
    int errors = 0;

    handshake_type1 #(
        .DATA_W(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_pre_i  (valid_pre_i),
        .data_pre_i   (data_pre_i),
        .ready_pre_o  (ready_pre_o),
        .valid_post_o (valid_post_o),
        .data_post_o  (data_post_o),
        .ready_post_i (ready_post_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(output logic fire);
        fire = valid_pre_i & ready_pre_o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic  fire;
        logic  stalled;
        logic  dfire;
        beat_t held;
        int    idx;
        int    nb;
        int    rx;
        int    bp [3];
        bp = '{8'h10, 8'h11, 8'h12};

        rst_n        = 1'b0;
        valid_pre_i  = 1'b1;
        data_pre_i   = 8'hAA;
        ready_post_i = 1'b1;
        #2;
        for (int c = 0; c < 5; c++) begin
            tick(fire);
            chk("rst_valid", valid_post_o, 1'b0);
            chk("rst_data", data_post_o, 8'h00);
            chk("rst_ready", ready_pre_o, 1'b0);
        end

        rst_n       = 1'b1;
        valid_pre_i = 1'b0;
        #2;
        tick(fire);
        chk("rel_valid", valid_post_o, 1'b0);
        chk("rel_ready", ready_pre_o, 1'b1);
        #2;
        tick(fire);
        chk("rel_nobeat", valid_post_o, 1'b0);

        for (int i = 0; i < 256; i++) begin
            valid_pre_i = 1'b1;
            data_pre_i  = 8'(i);
            #2;
            chk("stream_ready", ready_pre_o, 1'b1);
            tick(fire);
            chk("stream_valid", valid_post_o, 1'b1);
            chk("stream_data", data_post_o, 32'(i));
        end
        valid_pre_i = 1'b0;
        #2;
        tick(fire);
        chk("stream_end", valid_post_o, 1'b0);

        idx          = 0;
        ready_post_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            logic exp_rdy;
            valid_pre_i = idx < 3;
            data_pre_i  = (idx < 3) ? 8'(bp[idx]) : 8'h00;
            #2;
`ifdef HANDSHAKE_TYPE1_SKID_EN
            exp_rdy = c < 2;
`else
            exp_rdy = c == 0;
`endif
            chk("bp_ready", ready_pre_o, exp_rdy);
            tick(fire);
            if (fire)
                idx++;
            chk("bp_valid", valid_post_o, 1'b1);
            chk("bp_data", data_post_o, 8'h10);
        end
        ready_post_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid_pre_i = idx < 3;
            data_pre_i  = (idx < 3) ? 8'(bp[idx]) : 8'h00;
            #2;
            tick(fire);
            if (fire)
                idx++;
            chk("bp_order_valid", valid_post_o, 1'b1);
            chk("bp_order_data", data_post_o, 32'(8'h11 + k));
        end
        chk("bp_all_sent", idx, 3);
        valid_pre_i = 1'b0;
        #2;
        tick(fire);
        chk("bp_end", valid_post_o, 1'b0);

        ready_post_i = 1'b0;
        valid_pre_i  = 1'b1;
        data_pre_i   = 8'h20;
        #2;
        tick(fire);
        chk("df_load", data_post_o, 8'h20);
        valid_pre_i = 1'b0;
        #2;
        tick(fire);
        chk("df_hold", data_post_o, 8'h20);
        ready_post_i = 1'b1;
        valid_pre_i  = 1'b1;
        data_pre_i   = 8'h21;
        #2;
        chk("df_ready", ready_pre_o, 1'b1);
        tick(fire);
        chk("df_valid", valid_post_o, 1'b1);
        chk("df_data", data_post_o, 8'h21);
        valid_pre_i = 1'b0;
        #2;
        tick(fire);
        chk("df_end", valid_post_o, 1'b0);

        nb = 0;
        rx = 0;
        for (int c = 0; c < 150; c++) begin
            valid_pre_i  = 1'($urandom_range(0, 1));
            data_pre_i   = 8'(nb);
            ready_post_i = 1'($urandom_range(0, 1));
            #2;
            stalled = valid_post_o & ~ready_post_i;
            dfire   = valid_post_o & ready_post_i;
            held    = data_post_o;
            if (dfire) begin
                chk("rnd_seq", data_post_o, 32'(8'(rx)));
                rx++;
            end
            tick(fire);
            if (fire)
                nb++;
            if (stalled) begin
                chk("rnd_stable_valid", valid_post_o, 1'b1);
                chk("rnd_stable_data", data_post_o, held);
            end
        end
        valid_pre_i  = 1'b0;
        ready_post_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            if (valid_post_o) begin
                chk("rnd_drain_seq", data_post_o, 32'(8'(rx)));
                rx++;
            end
            tick(fire);
        end
        chk("rnd_count", rx, nb);
        chk("rnd_idle", valid_post_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_type1.md
# handshake_type1

Single-stage valid/ready pipeline register slice placed between an upstream sender and a downstream receiver on a streaming byte bus. Every accepted beat is registered once and presented downstream one cycle later, with full throughput and no loss, duplication or reordering. It breaks the combinational valid/data path. An optional skid mode also breaks the ready path.

## Interface
- DATA_W, 8, payload width in bits (≥1).
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- valid_pre_i  in  1  upstream beat valid.
- data_pre_i  in  DATA_W  upstream payload.
- ready_pre_o  out  1  slice can accept a beat this cycle.
- valid_post_o  out  1  registered beat valid to downstream.
- data_post_o  out  DATA_W  registered payload to downstream.
- ready_post_i  in  1  downstream accepts this cycle.

## Operation
- Transfer upstream: valid_pre_i & ready_pre_o at a rising edge. Transfer downstream: valid_post_o & ready_post_i at a rising edge.
- Base mode:
  - ready_pre_o = rst_n & (~valid_post_o | ready_post_i), combinational.
  - On each edge with ready_pre_o=1: valid_post_o <= valid_pre_i. If valid_pre_i is also 1: data_post_o <= data_pre_i.
  - Otherwise valid_post_o and data_post_o hold.
- Downstream stability: while valid_post_o=1 and ready_post_i=0, valid_post_o and data_post_o stay constant.
- data_post_o is don't-care when valid_post_o=0. It updates only on an upstream transfer, so no toggling on idle cycles.
- Simultaneous downstream and upstream transfer on the same edge: the output drains and reloads with the new beat in one cycle. There is no bubble.
- Upstream de-asserting valid_pre_i without a transfer is tolerated. No beat is captured.

## Timing
- Latency: a beat accepted at edge N is visible on valid_post_o/data_post_o after edge N. It can be consumed at edge N+1 at the earliest.
- Throughput: 1 beat/cycle when both sides are continuously ready/valid.
- Reset: on an edge with rst_n=0:
  - valid_post_o=0 and data_post_o=0.
  - Skid entry cleared.
  - ready_pre_o=0 for as long as rst_n=0.
  - A beat in flight during reset is discarded.
- First cycle after reset release: valid_post_o=0 and ready_pre_o=1.
- Base mode: ready_pre_o has a combinational path from ready_post_i.

## Configuration
- HANDSHAKE_TYPE1_SKID_EN undefined: base mode as above.
- HANDSHAKE_TYPE1_SKID_EN defined: two-entry skid slice.
  - ready_pre_o is a flop; there is no combinational path from ready_post_i. It equals "skid entry empty" and resets to 0, going to 1 on the first edge after rst_n=1.
  - If the output is stalled (valid_post_o & ~ready_post_i) and an upstream transfer occurs, the beat goes into the skid entry. ready_pre_o goes 0 on the next cycle.
  - When a downstream transfer occurs with the skid entry full, the output loads from the skid entry. The skid entry empties and ready_pre_o returns to 1 on the next cycle.
  - Latency, ordering, stability and reset values of valid_post_o/data_post_o are identical to base mode.
  - Throughput is 1 beat/cycle under continuous flow.

## Structure
- Shared package handshake_pkg holds the default DATA_W constant and a typedef for the beat payload (logic [DATA_W-1:0]).
- Sub-module handshake_type1_skid: the skid entry register plus its ready flop. It is instantiated only under HANDSHAKE_TYPE1_SKID_EN.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with valid_pre_i=1 and data 0xAA. Required: valid_post_o=0, data_post_o=0x00 and ready_pre_o=0 throughout. No beat emerges after release unless it is re-presented.
- Streaming: send 0x00..0xFF back-to-back with ready_post_i=1. Required: output 0x00..0xFF in order, one per cycle, first beat one cycle after its acceptance.
- Backpressure: stream 0x10,0x11,0x12 with ready_post_i=0 for 4 cycles.
  - Base mode: valid_post_o=1 and data_post_o=0x10 stable; ready_pre_o=0.
  - Skid mode: ready_pre_o drops one cycle after 0x11 is captured.
  - After ready_post_i=1, 0x10,0x11,0x12 arrive in order.
- Simultaneous drain and fill: output holds 0x20 with ready_post_i=1 and input 0x21 valid. Required: next cycle data_post_o=0x21, valid_post_o=1, no idle cycle.
- Random stalls: 150 cycles of independent random valid_pre_i and ready_post_i from an incrementing-byte source. The receiver-side scoreboard must see a strictly incrementing sequence with no gaps or repeats, and stability holds on every stalled cycle.
- Run all of the above with and without HANDSHAKE_TYPE1_SKID_EN.
